// File: rtl/ps2_key_controller.sv
// PS/2 set-2 scancode decoder feeding a show-ahead key-event FIFO.
// Handshake: scancode is consumed on every cycle scancode_valid=1; an event is
// popped on a cycle where rd_req=1 and key_valid=1 (rd_req is ignored otherwise).
module ps2_key_controller #(
  parameter int FIFO_DEPTH = 8,
  parameter int PAUSE_LEN  = 7
) (
  input  logic                        clk_cpu,
  input  logic                        reset,
  input  logic [7:0]                  scancode,
  input  logic                        scancode_valid,
  input  logic                        rd_req,
  input  logic                        clr_overflow,
  output logic [7:0]                  key_code,
  output logic                        key_release,
  output logic                        key_extended,
  output logic                        key_valid,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  // Decoder state is kept as a named enum so checkers can bind to it directly.
  state_t          state;
  logic [DW-1:0]   discard_cnt;

  logic            push;
  logic [9:0]      push_data;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic [9:0]      head;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Decide whether the current byte completes an event, and what it is.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (scancode_valid) begin
      case (state)
        IDLE: begin
          if (scancode != 8'hE0 && scancode != 8'hF0 && scancode != 8'hE1 &&
              !is_filler(scancode)) begin
            push      = 1'b1;
            push_data = {2'b00, scancode};
          end
        end
        EXT: begin
          if (scancode != 8'hF0 && scancode != 8'hE0) begin
            push      = 1'b1;
            push_data = {2'b10, scancode};
          end
        end
        BRK: begin
          push      = 1'b1;
          push_data = {2'b01, scancode};
        end
        EXT_BRK: begin
          push      = 1'b1;
          push_data = {2'b11, scancode};
        end
        PAUSE: begin
          // The byte that takes the counter to zero completes the Pause key.
          if (discard_cnt <= DW'(1)) begin
            push      = 1'b1;
            push_data = {2'b00, 8'hE1};
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix-tracking FSM; only moves on received bytes.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      discard_cnt <= '0;
    end else if (scancode_valid) begin
      case (state)
        IDLE: begin
          if (scancode == 8'hE0)      state <= EXT;
          else if (scancode == 8'hF0) state <= BRK;
          else if (scancode == 8'hE1) begin
            state       <= PAUSE;
            discard_cnt <= DW'(PAUSE_LEN);
          end
        end
        EXT: begin
          if (scancode == 8'hF0)      state <= EXT_BRK;
          else if (scancode != 8'hE0) state <= IDLE;
        end
        BRK:     state <= IDLE;
        EXT_BRK: state <= IDLE;
        PAUSE: begin
          if (discard_cnt != '0) discard_cnt <= discard_cnt - DW'(1);
          if (discard_cnt <= DW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = rd_req && (count != '0);
  // When full, a simultaneous pop frees the slot the write pointer lands on.
  assign wr_en = push && (!full || pop);

  // Storage array carries no reset; stale entries are masked by key_valid.
  always_ff @(posedge clk_cpu) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the sticky drop flag (set beats clear).
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr];
  assign key_valid    = (count != '0);
  assign key_code     = key_valid ? head[7:0] : 8'h00;
  assign key_release  = key_valid ? head[8]   : 1'b0;
  assign key_extended = key_valid ? head[9]   : 1'b0;
  assign fifo_full    = full;
  assign fifo_count   = count;

endmodule

// File: doc/ps2_key_controller.md
PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, key-event FIFO depth; power of two, minimum 2.
REQ-002 SHALL have parameter PAUSE_LEN, default 7, number of bytes discarded after an 0xE1 prefix.
REQ-003 SHALL have port clk_cpu, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port scancode, input, 8 bits: received byte from the PS/2 receiver.
REQ-006 SHALL have port scancode_valid, input, 1 bit: one-cycle pulse in the clk_cpu domain qualifying scancode.
REQ-007 SHALL have port rd_req, input, 1 bit: pops the head event when key_valid=1.
REQ-008 SHALL have port clr_overflow, input, 1 bit: clears the overflow flag.
REQ-009 SHALL have port key_code, output, 8 bits: head event code (show-ahead).
REQ-010 SHALL have port key_release, output, 1 bit: head event is a break (key up).
REQ-011 SHALL have port key_extended, output, 1 bit: head event carried an 0xE0 prefix.
REQ-012 SHALL have port key_valid, output, 1 bit: FIFO not empty.
REQ-013 SHALL have port fifo_full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-014 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, an event was dropped.

Function
REQ-016 SHALL run a decode FSM with states IDLE, EXT, BRK, EXT_BRK and PAUSE; the FSM advances only on cycles where scancode_valid=1.
REQ-017 In IDLE, the FSM SHALL act on the received byte as follows:
- 0xE0: go to EXT.
- 0xF0: go to BRK.
- 0xE1: go to PAUSE and load the discard counter with PAUSE_LEN.
- 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: drop the byte, stay in IDLE.
- Any other byte: push {ext=0, rel=0, code}.
REQ-018 In EXT, the FSM SHALL act on the received byte as follows:
- 0xF0: go to EXT_BRK.
- 0xE0: stay in EXT.
- Any other byte: push {ext=1, rel=0, code} and go to IDLE.
REQ-019 In BRK, any byte SHALL push {ext=0, rel=1, code} and return to IDLE.
REQ-020 In EXT_BRK, any byte SHALL push {ext=1, rel=1, code} and return to IDLE.
REQ-021 In PAUSE, each byte SHALL decrement the counter; when the counter reaches 0, the block SHALL push {ext=0, rel=0, 0xE1} and return to IDLE.
REQ-022 Push-to-visible latency SHALL be one cycle: a push on the scancode_valid cycle N makes the entry visible on key_* at N+1.
REQ-023 FIFO entries SHALL be 10 bits {ext, rel, code}, ordered first-in first-out; read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 rd_req while key_valid=0 SHALL be ignored, with no pointer or count change.
REQ-025 Push and pop in the same cycle when not empty SHALL both take effect, leaving fifo_count unchanged.
REQ-026 Push and pop in the same cycle when full SHALL accept the push, with no drop and overflow unchanged.
REQ-027 Push while empty together with rd_req SHALL store the entry, with the pop ignored.
REQ-028 Push while full without pop SHALL drop the event, leave the FIFO contents untouched, and set overflow on the next edge.
REQ-029 overflow SHALL clear only on clr_overflow; if a set and a clear occur in the same cycle, set wins.
REQ-030 key_code, key_release and key_extended SHALL read as 0 whenever key_valid=0.
REQ-031 fifo_full SHALL equal (fifo_count == FIFO_DEPTH).

Reset
REQ-032 reset SHALL act asynchronously and force: FSM=IDLE, discard counter=0, pointers=0, fifo_count=0, key_valid=0, fifo_full=0, overflow=0, key_code=0, key_release=0, key_extended=0.
REQ-033 reset asserted mid-sequence (e.g. after 0xE0 or during PAUSE) SHALL discard the partial prefix; the first byte after deassertion is decoded from IDLE.
REQ-034 FIFO contents need not be cleared by reset; they SHALL be unobservable while key_valid=0.

Verification
REQ-035 Bytes 0x1C, then 0xF0, 0x1C -> two entries: {0,0,0x1C} then {0,1,0x1C}; fifo_count=2.
REQ-036 Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> entries {1,0,0x75}, {1,1,0x75}; no other entries.
REQ-037 Bytes 0xE1,0x14,0x77,0xE1,0xF0,0x14,0xF0,0x77 -> exactly one entry {0,0,0xE1}.
REQ-038 Nine make codes with no reads (FIFO_DEPTH=8) -> fifo_full=1, overflow=1, head still the first code; clr_overflow -> overflow=0.
REQ-039 Full FIFO plus a simultaneous push and rd_req -> count stays 8, overflow=0, new code appears at the tail.
REQ-040 Byte 0xE0, then reset pulse, then 0x1C -> entry {0,0,0x1C}; 0xAA and 0xFA in IDLE -> no entries.
